// File: rtl/rpi_bus_data_fifo_pkg.sv
// rpi_bus_pkg: shared definitions for the RPi parallel-bus data FIFO peripheral.
//  - Register offsets inside the 4-address bank
//  - Status word bit positions
//  - FIFO occupancy-count width helper
package rpi_bus_pkg;

    typedef enum logic [1:0] {
        OFF_TX      = 2'd0,
        OFF_RX      = 2'd1,
        OFF_STATUS  = 2'd2,
        OFF_SCRATCH = 2'd3
    } reg_offset_e;

    localparam int RX_EMPTY_BIT = 31;
    localparam int RX_FULL_BIT  = 30;
    localparam int TX_EMPTY_BIT = 29;
    localparam int TX_FULL_BIT  = 28;
    localparam int TX_OVF_LSB   = 24;
    localparam int RX_UNF_LSB   = 20;
    localparam int RX_COUNT_LSB = 8;
    localparam int TX_COUNT_LSB = 0;
    localparam int ERR_CNT_W    = 4;

    // One extra bit so a completely full FIFO is distinguishable from empty.
    function automatic int count_width(input int log2_depth);
        return log2_depth + 1;
    endfunction

endpackage

// File: rtl/rpi_bus_data_fifo_if.sv
// rpi_bus_data_fifo_if: RPi parallel-bus signals seen by a bus peripheral.
//  address          bus address word (master -> slave)
//  write_strobe     1-cycle write pulse (master -> slave)
//  write_data_word  write data (master -> slave)
//  read_strobe      read level, high >= 1 cycle per read (master -> slave)
//  read_data_word   registered readback (slave -> master)
interface rpi_bus_data_fifo_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write_strobe;
    logic [DATA_WIDTH-1:0]    write_data_word;
    logic                     read_strobe;
    logic [DATA_WIDTH-1:0]    read_data_word;

    modport master (
        output address, write_strobe, write_data_word, read_strobe,
        input  read_data_word
    );

    modport slave (
        input  address, write_strobe, write_data_word, read_strobe,
        output read_data_word
    );
endinterface

// File: rtl/rpi_bus_sync_fifo.sv
// rpi_bus_sync_fifo: single-clock first-word-fall-through FIFO.
//  clock, reset  system clock, synchronous active-high reset
//  push/push_data  write request and data
//  pop             read request (advances head)
//  head            current head word (stale when empty)
//  full/empty/count  occupancy flags and count (LOG2_OF_DEPTH+1 bits)
module rpi_bus_sync_fifo
    import rpi_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int LOG2_OF_DEPTH = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   push,
    input  logic [DATA_WIDTH-1:0]                  push_data,
    input  logic                                   pop,
    output logic [DATA_WIDTH-1:0]                  head,
    output logic                                   full,
    output logic                                   empty,
    output logic [count_width(LOG2_OF_DEPTH)-1:0]  count
);
    localparam int CW    = count_width(LOG2_OF_DEPTH);
    localparam int DEPTH = 2 ** LOG2_OF_DEPTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;

    assign count  = wr_ptr - rd_ptr;
    assign full   = count == CW'(DEPTH);
    assign empty  = count == '0;
    assign head   = mem[rd_ptr[LOG2_OF_DEPTH-1:0]];
    // Push and pop together on an empty FIFO: the word passes straight through.
    assign bypass = empty && push && pop;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign wr_en  = push && (!full || pop) && !bypass;
    assign rd_en  = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !reset) mem[wr_ptr[LOG2_OF_DEPTH-1:0]] <= push_data;
    end
endmodule

// File: rtl/rpi_bus_data_fifo.sv
// rpi_bus_data_fifo: RPi parallel-bus peripheral mapping a TX FIFO, RX FIFO,
// status word and scratch register into 4 consecutive addresses.
//  clock, reset          system clock, synchronous active-high reset
//  bus (slave)           address / write_strobe / write_data_word / read_strobe / read_data_word
//  tx_data/tx_valid/tx_ready  TX FIFO head to fabric (pop on valid && ready)
//  rx_data/rx_valid/rx_ready  fabric push into RX FIFO (ready = not full)
// Map: +0 TX push / TX head, +1 RX pop, +2 status, +3 scratch.
// Optional macro RPI_BUS_DATA_FIFO_ERROR_COUNTERS_EN adds saturating TX-overflow and
// RX-underflow counters (status [27:20]), cleared by any write to +2.
module rpi_bus_data_fifo
    import rpi_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int LOG2_OF_DEPTH = 4,
    parameter int BASE_ADDRESS  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    rpi_bus_data_fifo_if.slave    bus,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);
    localparam int CW = count_width(LOG2_OF_DEPTH);

    logic [ADDRESS_WIDTH-1:0] offset;
    logic                     hit;
    reg_offset_e              sel;
    logic                     strobe_q;
    logic                     read_rise;
    logic                     tx_push, tx_pop, rx_push, rx_pop;
    logic [DATA_WIDTH-1:0]    tx_head, rx_head;
    logic                     tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]            tx_count, rx_count;
    logic [DATA_WIDTH-1:0]    scratch;
    logic [DATA_WIDTH-1:0]    read_data;
    logic [DATA_WIDTH-1:0]    read_next;
    logic [31:0]              status;
    logic [ERR_CNT_W-1:0]     tx_ovf;
    logic [ERR_CNT_W-1:0]     rx_unf;

    // Unsigned subtraction makes addresses below the base wrap high and miss.
    assign offset    = bus.address - ADDRESS_WIDTH'(BASE_ADDRESS);
    assign hit       = offset < ADDRESS_WIDTH'(4);
    assign sel       = reg_offset_e'(offset[1:0]);
    assign read_rise = bus.read_strobe && !strobe_q;
    assign tx_push   = bus.write_strobe && hit && sel == OFF_TX;
    assign tx_pop    = tx_valid && tx_ready;
    assign rx_push   = rx_valid && rx_ready;
    assign rx_pop    = read_rise && hit && sel == OFF_RX;
    assign tx_valid  = !tx_empty;
    assign rx_ready  = !rx_full;
    assign tx_data   = tx_head;

    rpi_bus_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .LOG2_OF_DEPTH(LOG2_OF_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (bus.write_data_word),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    rpi_bus_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .LOG2_OF_DEPTH(LOG2_OF_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

`ifdef RPI_BUS_DATA_FIFO_ERROR_COUNTERS_EN
    logic tx_overflow;
    logic rx_underflow;
    logic status_write;

    assign tx_overflow  = tx_push && tx_full && !tx_pop;
    // A pop that meets a same-cycle push on an empty FIFO consumes that word.
    assign rx_underflow = rx_pop && rx_empty && !rx_push;
    assign status_write = bus.write_strobe && hit && sel == OFF_STATUS;

    always_ff @(posedge clock) begin
        if (reset || status_write) begin
            tx_ovf <= '0;
            rx_unf <= '0;
        end else begin
            if (tx_overflow && tx_ovf != '1) tx_ovf <= tx_ovf + 1'b1;
            if (rx_underflow && rx_unf != '1) rx_unf <= rx_unf + 1'b1;
        end
    end
`else
    assign tx_ovf = '0;
    assign rx_unf = '0;
`endif

    always_comb begin
        status                              = '0;
        status[RX_EMPTY_BIT]                = rx_empty;
        status[RX_FULL_BIT]                 = rx_full;
        status[TX_EMPTY_BIT]                = tx_empty;
        status[TX_FULL_BIT]                 = tx_full;
        status[TX_OVF_LSB +: ERR_CNT_W]     = tx_ovf;
        status[RX_UNF_LSB +: ERR_CNT_W]     = rx_unf;
        status[RX_COUNT_LSB +: CW]          = rx_count;
        status[TX_COUNT_LSB +: CW]          = tx_count;
    end

    assign read_next = !hit                ? '0 :
                       sel == OFF_TX       ? (tx_empty ? '0 : tx_head) :
                       sel == OFF_RX       ? (rx_empty ? '0 : rx_head) :
                       sel == OFF_STATUS   ? DATA_WIDTH'(status) :
                                             scratch;

    // strobe_q resets high so a strobe held across reset cannot pop on the first cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_q  <= 1'b1;
            scratch   <= '0;
            read_data <= '0;
        end else begin
            strobe_q  <= bus.read_strobe;
            read_data <= read_next;
            if (bus.write_strobe && hit && sel == OFF_SCRATCH) scratch <= bus.write_data_word;
        end
    end

    assign bus.read_data_word = read_data;
endmodule

// File: tb/tb_rpi_bus_data_fifo.sv
// tb_rpi_bus_data_fifo: directed and randomized checks of rpi_bus_data_fifo against a queue model.
module tb_rpi_bus_data_fifo;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int L2    = 4;
    localparam int DEPTH = 16;
    localparam int BASE  = 0;
`ifdef RPI_BUS_DATA_FIFO_ERROR_COUNTERS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;

    rpi_bus_data_fifo_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    rpi_bus_data_fifo #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LOG2_OF_DEPTH(L2), .BASE_ADDRESS(BASE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] m_scratch = '0;
    logic [3:0]    m_ovf = '0;
    logic [3:0]    m_unf = '0;
    logic          m_prev = 1'b1;
    logic [DW-1:0] m_rd = '0;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[31]    = rx_q.size() == 0;
        s[30]    = rx_q.size() == DEPTH;
        s[29]    = tx_q.size() == 0;
        s[28]    = tx_q.size() == DEPTH;
        s[27:24] = ERR_EN ? m_ovf : 4'h0;
        s[23:20] = ERR_EN ? m_unf : 4'h0;
        s[15:8]  = 8'(rx_q.size());
        s[7:0]   = 8'(tx_q.size());
        return s;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        int off;
        off = int'(a) - BASE;
        if (off == 0) return tx_q.size() != 0 ? tx_q[0] : '0;
        if (off == 1) return rx_q.size() != 0 ? rx_q[0] : '0;
        if (off == 2) return model_status();
        if (off == 3) return m_scratch;
        return '0;
    endfunction

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic step();
        int off;
        int tsz, rsz;
        bit tpop, tpush, rpop, rpush, ws, rs, rst;
        logic [DW-1:0] nxt, wd, rxd;
        nxt   = model_read(bus.address);
        off   = int'(bus.address) - BASE;
        ws    = bus.write_strobe;
        rs    = bus.read_strobe;
        wd    = bus.write_data_word;
        rxd   = rx_data;
        rst   = reset;
        tsz   = tx_q.size();
        rsz   = rx_q.size();
        tpop  = tsz > 0 && tx_ready;
        tpush = ws && off == 0;
        rpop  = rs && !m_prev && off == 1;
        rpush = rx_valid && rsz < DEPTH;
        @(posedge clock);
        #1;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_scratch = '0;
            m_ovf = '0;
            m_unf = '0;
            m_prev = 1'b1;
            m_rd = '0;
        end else begin
            if (tpop) void'(tx_q.pop_front());
            if (tpush) begin
                if (tsz < DEPTH || tpop) tx_q.push_back(wd);
                else if (m_ovf != 4'hf) m_ovf++;
            end
            if (rpop && rsz > 0) void'(rx_q.pop_front());
            if (rpop && rsz == 0 && !rpush && m_unf != 4'hf) m_unf++;
            if (rpush && !(rpop && rsz == 0)) rx_q.push_back(rxd);
            if (ws && off == 2 && ERR_EN) begin
                m_ovf = '0;
                m_unf = '0;
            end
            if (ws && off == 3) m_scratch = wd;
            m_prev = rs;
            m_rd = nxt;
        end
    endtask

    task automatic bus_write(input int a, input logic [DW-1:0] d);
        bus.address = AW'(a);
        bus.write_data_word = d;
        bus.write_strobe = 1'b1;
        step();
        bus.write_strobe = 1'b0;
    endtask

    task automatic bus_read(input int a);
        bus.address = AW'(a);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.address = '0;
        bus.write_strobe = 1'b0;
        bus.write_data_word = '0;
        bus.read_strobe = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        vectors++;
        if (bus.read_data_word !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want %h", bus.read_data_word, 32'h0);
        end
        vectors++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_flags: got tx_valid=%b rx_ready=%b want 0 1", tx_valid, rx_ready);
        end
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word !== 32'hA000_0000) begin
            miscompares++;
            $display("FAIL reset_status: got %h want %h", bus.read_data_word, 32'hA000_0000);
        end
    endtask

    task automatic test_tx_push();
        tx_ready = 1'b0;
        bus_write(BASE + 0, 32'h1234_5678);
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL tx_push: got valid=%b data=%h want 1 %h", tx_valid, tx_data, 32'h1234_5678);
        end
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word[7:0] !== 8'd1) begin
            miscompares++;
            $display("FAIL tx_count1: got %0d want 1", bus.read_data_word[7:0]);
        end
    endtask

    task automatic test_tx_overflow();
        for (int i = 1; i < DEPTH; i++) bus_write(BASE + 0, $urandom);
        bus_write(BASE + 0, 32'hBAD0_0017);
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word[7:0] !== 8'd16 || bus.read_data_word[28] !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_full: got count=%0d full=%b want 16 1", bus.read_data_word[7:0], bus.read_data_word[28]);
        end
        vectors++;
        if (bus.read_data_word[27:24] !== (ERR_EN ? 4'd1 : 4'd0)) begin
            miscompares++;
            $display("FAIL tx_overflows: got %0d want %0d", bus.read_data_word[27:24], ERR_EN ? 1 : 0);
        end
        vectors++;
        if (tx_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL tx_head_kept: got %h want %h", tx_data, 32'h1234_5678);
        end
    endtask

    task automatic test_rx_level_pop();
        rx_valid = 1'b1;
        rx_data = 32'hCAFE_0001;
        step();
        rx_data = 32'hCAFE_0002;
        step();
        rx_valid = 1'b0;
        bus.address = AW'(BASE + 1);
        bus.read_strobe = 1'b1;
        step();
        vectors++;
        if (bus.read_data_word !== 32'hCAFE_0001) begin
            miscompares++;
            $display("FAIL rx_first_read: got %h want %h", bus.read_data_word, 32'hCAFE_0001);
        end
        repeat (4) step();
        bus.read_strobe = 1'b0;
        step();
        vectors++;
        if (bus.read_data_word !== 32'hCAFE_0002) begin
            miscompares++;
            $display("FAIL rx_single_pop: got %h want %h", bus.read_data_word, 32'hCAFE_0002);
        end
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word[15:8] !== 8'd1) begin
            miscompares++;
            $display("FAIL rx_count1: got %0d want 1", bus.read_data_word[15:8]);
        end
    endtask

    task automatic test_rx_underflow();
        bus.address = AW'(BASE + 1);
        bus.read_strobe = 1'b1;
        step();
        bus.read_strobe = 1'b0;
        step();
        bus.read_strobe = 1'b1;
        step();
        bus.read_strobe = 1'b0;
        step();
        vectors++;
        if (bus.read_data_word !== 32'h0) begin
            miscompares++;
            $display("FAIL rx_empty_read: got %h want 0", bus.read_data_word);
        end
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word[23:20] !== (ERR_EN ? 4'd1 : 4'd0) || bus.read_data_word[15:8] !== 8'd0) begin
            miscompares++;
            $display("FAIL rx_underflow: got unf=%0d count=%0d want %0d 0",
                     bus.read_data_word[23:20], bus.read_data_word[15:8], ERR_EN ? 1 : 0);
        end
    endtask

    task automatic test_full_push_pop_and_reset();
        tx_ready = 1'b1;
        bus_write(BASE + 0, 32'h5A5A_0001);
        tx_ready = 1'b0;
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word[7:0] !== 8'd16 || bus.read_data_word[27:24] !== (ERR_EN ? 4'd1 : 4'd0)) begin
            miscompares++;
            $display("FAIL full_push_pop: got count=%0d ovf=%0d want 16 %0d",
                     bus.read_data_word[7:0], bus.read_data_word[27:24], ERR_EN ? 1 : 0);
        end
        vectors++;
        if (tx_data !== tx_q[0]) begin
            miscompares++;
            $display("FAIL full_push_pop_head: got %h want %h", tx_data, tx_q[0]);
        end
        bus_write(BASE + 2, 32'hFFFF_FFFF);
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word[27:20] !== 8'h0) begin
            miscompares++;
            $display("FAIL counter_clear: got %h want 0", bus.read_data_word[27:20]);
        end
        bus_write(BASE + 3, 32'hDEAD_BEEF);
        bus_read(BASE + 3);
        vectors++;
        if (bus.read_data_word !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL scratch: got %h want %h", bus.read_data_word, 32'hDEAD_BEEF);
        end
        tx_ready = 1'b1;
        rx_valid = 1'b1;
        rx_data = 32'h7777_7777;
        bus.address = AW'(BASE + 0);
        bus.write_data_word = 32'h0BAD_F00D;
        bus.write_strobe = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.write_strobe = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        bus_read(BASE + 2);
        vectors++;
        if (bus.read_data_word !== 32'hA000_0000 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_reset: got status=%h tx_valid=%b want %h 0",
                     bus.read_data_word, tx_valid, 32'hA000_0000);
        end
        bus_read(BASE + 3);
        vectors++;
        if (bus.read_data_word !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_scratch: got %h want 0", bus.read_data_word);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            reset = $urandom_range(0, 199) == 0;
            r = $urandom_range(0, 9);
            bus.address = r < 8 ? AW'(BASE + r % 4) : AW'($urandom);
            bus.write_strobe = $urandom_range(0, 3) == 0;
            bus.write_data_word = $urandom;
            if ($urandom_range(0, 2) == 0) bus.read_strobe = !bus.read_strobe;
            tx_ready = $urandom_range(0, 1) == 1;
            rx_valid = $urandom_range(0, 2) != 0;
            rx_data = $urandom;
            step();
            vectors++;
            if (bus.read_data_word !== m_rd) begin
                miscompares++;
                $display("FAIL rand_rdata[%0d]: got %h want %h", i, bus.read_data_word, m_rd);
            end
            vectors++;
            if (tx_valid !== (tx_q.size() != 0) || rx_ready !== (rx_q.size() < DEPTH)) begin
                miscompares++;
                $display("FAIL rand_flags[%0d]: got tx_valid=%b rx_ready=%b want %b %b",
                         i, tx_valid, rx_ready, tx_q.size() != 0, rx_q.size() < DEPTH);
            end
            if (tx_q.size() != 0) begin
                vectors++;
                if (tx_data !== tx_q[0]) begin
                    miscompares++;
                    $display("FAIL rand_tx_data[%0d]: got %h want %h", i, tx_data, tx_q[0]);
                end
            end
        end
        reset = 1'b0;
        bus.write_strobe = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_push();
        test_tx_overflow();
        test_rx_level_pop();
        test_rx_underflow();
        test_full_push_pop_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
